// File: rtl/serial_addsub_word.sv
// Digit-serial two's-complement add/subtract over one framed word, LSD first.
// Optional SERIAL_ADDSUB_ZERO_FLAG_EN adds a whole-word zero flag on the last digit.

module serial_addsub_digit #(
  parameter int W = 1
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);
  logic [W-1:0] yx;
  logic [W:0]   t;

  assign yx   = y ^ {W{sub}};
  assign t    = {1'b0, x} + {1'b0, yx} + {{W{1'b0}}, cin};
  assign s    = t[W-1:0];
  assign cout = t[W];
  // Carry into the top bit recovered from the top-bit sum, valid for any W.
  assign cmsb = x[W-1] ^ yx[W-1] ^ s[W-1];
endmodule

module serial_addsub_word #(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] x_in,
  input  logic [DIGIT_W-1:0] y_in,
  output logic               busy,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] sum_out,
  output logic               last,
  output logic               carry_out,
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  output logic               zero,
`endif
  output logic               overflow
);
  localparam int CW = (WORD_DIGITS > 2) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_DIGITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              carry_reg, sub_reg;
  logic              accept, fin, launch;
  logic [DIGIT_W-1:0] s;
  logic              c, cmsb;

  serial_addsub_digit #(.W(DIGIT_W)) u_digit (
    .x   (x_in),
    .y   (y_in),
    .cin (carry_reg),
    .sub (sub_reg),
    .s   (s),
    .cout(c),
    .cmsb(cmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fin       = 1'b0;
    launch    = 1'b0;
    case (state)
      IDLE: if (start) begin
        launch    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (in_valid) begin
        accept = 1'b1;
        if (cnt == CNT_LAST) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      carry_reg <= 1'b0;
      sub_reg   <= 1'b0;
      out_valid <= 1'b0;
      sum_out   <= '0;
      last      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= accept;
      last      <= fin;
      carry_out <= fin & c;
      overflow  <= fin & (c ^ cmsb);
      if (launch) begin
        // Subtract is x + ~y + 1: the +1 enters as the initial carry.
        sub_reg   <= sub;
        carry_reg <= sub;
        cnt       <= '0;
      end
      if (accept) begin
        sum_out   <= s;
        carry_reg <= c;
        cnt       <= fin ? '0 : cnt + CW'(1);
      end
    end
  end

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  logic zero_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_acc <= 1'b0;
      zero     <= 1'b0;
    end else begin
      zero <= fin & zero_acc & (s == '0);
      if (launch)      zero_acc <= 1'b1;
      else if (accept) zero_acc <= zero_acc & (s == '0);
    end
  end
`endif

endmodule
